// File: rtl/sseg_ctrl.sv
// Four-digit multiplexed common-anode seven-segment driver. Latches a 16-bit
// value and decimal-point mask from a start/done handshake and scans the digits.
module sseg_ctrl #(
  parameter int REFRESH_CLOCKS = 4096,
  parameter int GUARD_CLOCKS   = 16,
  parameter int BLANK_ZEROS    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [15:0] in1,
  input  logic [3:0]  in2,
  output logic        done_port,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [15:0] CNT_LAST = 16'(REFRESH_CLOCKS - 1);

  logic [15:0] val_q, val_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        in_guard;
  logic [3:0]  nibs [4];
  logic [3:0]  upper_zero;
  logic        blank_digit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  generate
    if (GUARD_CLOCKS == 0) begin : g_noguard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_q < 16'(GUARD_CLOCKS));
    end
  endgenerate

  // upper_zero[k]: nibble k and every nibble above it are zero (digit 0 exempt)
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nibs[gi] = val_q[4*gi+3 -: 4];
      if (gi == 0) begin : g_first
        assign upper_zero[gi] = 1'b0;
      end else begin : g_upper
        assign upper_zero[gi] = (val_q[15:4*gi] == '0);
      end
    end
  endgenerate

  assign blank_digit = (BLANK_ZEROS != 0) && upper_zero[idx_q];

  always_comb begin
    val_d  = val_q;
    mask_d = mask_q;
    done_d = start_port;
    cnt_d  = cnt_q + 16'd1;
    idx_d  = idx_q;
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;

    if (start_port) begin
      val_d  = in1;
      mask_d = in2;
    end

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Outputs track the current latched value, so a write shows up mid-slot
    if (!in_guard) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank_digit ? 7'h7F : decode(nibs[idx_q]);
      dp_d  = ~mask_q[idx_q];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      val_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      an_q   <= 4'hF;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      val_q  <= val_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign done_port = done_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_sseg_ctrl.sv
// Bench for sseg_ctrl: two instances (no blanking / blanking) checked every
// cycle against a frame-position model, plus literal checks of key scenarios.
module tb_sseg_ctrl;

  localparam int R = 8;
  localparam int G = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_port;
  logic [15:0] in1;
  logic [3:0]  in2;

  logic        done_a, dp_a, done_b, dp_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  always #5 clock = ~clock;

  sseg_ctrl #(.REFRESH_CLOCKS(R), .GUARD_CLOCKS(G), .BLANK_ZEROS(0)) u_dut (
    .clock(clock), .reset(reset), .start_port(start_port), .in1(in1), .in2(in2),
    .done_port(done_a), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  sseg_ctrl #(.REFRESH_CLOCKS(R), .GUARD_CLOCKS(G), .BLANK_ZEROS(1)) u_dut_b (
    .clock(clock), .reset(reset), .start_port(start_port), .in1(in1), .in2(in2),
    .done_port(done_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  // Reference model: frame position is just elapsed cycles since reset
  logic [6:0]  dec_tab [16];
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_mask;
  logic [3:0]  e_an;
  logic [6:0]  e_seg0, e_seg1;
  logic        e_dp, e_done;
  logic        m_valid = 1'b0;

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  always @(posedge clock) begin
    int c, d;
    logic [15:0] upper;
    logic [3:0]  one;
    if (!reset) begin
      m_t     <= 0;
      m_val   <= '0;
      m_mask  <= '0;
      e_an    <= 4'hF;
      e_seg0  <= 7'h7F;
      e_seg1  <= 7'h7F;
      e_dp    <= 1'b1;
      e_done  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      c = m_t % R;
      d = (m_t / R) % 4;
      one = 4'b0001;
      upper = m_val >> (4 * d);
      if (c < G) begin
        e_an   <= 4'hF;
        e_seg0 <= 7'h7F;
        e_seg1 <= 7'h7F;
        e_dp   <= 1'b1;
      end else begin
        e_an   <= ~(one << d);
        e_seg0 <= dec_tab[upper[3:0]];
        e_seg1 <= (d > 0 && upper == 16'h0) ? 7'h7F : dec_tab[upper[3:0]];
        e_dp   <= ~m_mask[d];
      end
      e_done <= start_port;
      if (start_port) begin
        m_val  <= in1;
        m_mask <= in2;
      end
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model an_a",   16'(an_a),   16'(e_an));
      chk("model seg_a",  16'(seg_a),  16'(e_seg0));
      chk("model dp_a",   16'(dp_a),   16'(e_dp));
      chk("model done_a", 16'(done_a), 16'(e_done));
      chk("model an_b",   16'(an_b),   16'(e_an));
      chk("model seg_b",  16'(seg_b),  16'(e_seg1));
      chk("model dp_b",   16'(dp_b),   16'(e_dp));
      chk("model done_b", 16'(done_b), 16'(e_done));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      e++;
    end
  endtask

  // Step until outputs reflect scan state (digit d, count c); e edges since release
  task automatic advance_to(input int d, input int c);
    int n = 0;
    while (!(((e - 1) % R == c) && (((e - 1) / R) % 4 == d)) && n < 80) begin
      step(1);
      n++;
    end
    if (n >= 80) begin
      total++;
      bad++;
      $display("FAIL advance_to timeout: got no slot want digit %0d cnt %0d", d, c);
    end
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] m);
    start_port = 1'b1;
    in1 = v;
    in2 = m;
    step(1);
    start_port = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    start_port = 1'b0;
    in1 = '0;
    in2 = '0;
    repeat (5) @(negedge clock);
    chk("rst an",   16'(an_a),   16'hF);
    chk("rst seg",  16'(seg_a),  16'h7F);
    chk("rst dp",   16'(dp_a),   16'h1);
    chk("rst done", 16'(done_a), 16'h0);

    reset = 1'b1;
    e = 0;
    step(2);
    chk("guard an after 2", 16'(an_a), 16'hF);
    step(1);
    chk("first an after 3", 16'(an_a), 16'hE);
    step(6);
    chk("slot1 guard an", 16'(an_a), 16'hF);
    step(2);
    chk("slot1 an", 16'(an_a), 16'hD);
    chk("slot1 blank seg_b", 16'(seg_b), 16'h7F);
    step(24);
    chk("wrap an", 16'(an_a), 16'hE);

    write(16'h12AF, 4'b0100);
    chk("done pulse", 16'(done_a), 16'h1);
    step(1);
    chk("done drop", 16'(done_a), 16'h0);
    advance_to(0, 4);
    chk("d0 an", 16'(an_a), 16'hE);
    chk("d0 seg", 16'(seg_a), 16'h0E);
    chk("d0 dp", 16'(dp_a), 16'h1);
    advance_to(1, 4);
    chk("d1 an", 16'(an_a), 16'hD);
    chk("d1 seg", 16'(seg_a), 16'h08);
    advance_to(2, 4);
    chk("d2 an", 16'(an_a), 16'hB);
    chk("d2 seg", 16'(seg_a), 16'h24);
    chk("d2 dp", 16'(dp_a), 16'h0);
    advance_to(3, 4);
    chk("d3 an", 16'(an_a), 16'h7);
    chk("d3 seg", 16'(seg_a), 16'h79);

    write(16'h0050, 4'b0000);
    advance_to(0, 5);
    chk("blank d0 seg", 16'(seg_b), 16'h40);
    advance_to(1, 5);
    chk("blank d1 seg", 16'(seg_b), 16'h12);
    advance_to(2, 5);
    chk("blank d2 seg", 16'(seg_b), 16'h7F);
    chk("blank d2 an", 16'(an_b), 16'hB);
    advance_to(3, 5);
    chk("blank d3 seg", 16'(seg_b), 16'h7F);
    chk("blank d3 an", 16'(an_b), 16'h7);
    write(16'h0000, 4'b0000);
    advance_to(0, 5);
    chk("zero d0 seg", 16'(seg_b), 16'h40);
    advance_to(1, 5);
    chk("zero d1 seg", 16'(seg_b), 16'h7F);

    write(16'h0003, 4'b0000);
    advance_to(0, 3);
    chk("mid before", 16'(seg_a), 16'h30);
    write(16'h0008, 4'b0000);
    chk("mid latch edge", 16'(seg_a), 16'h30);
    step(1);
    chk("mid after", 16'(seg_a), 16'h00);
    chk("mid an", 16'(an_a), 16'hE);

    start_port = 1'b1;
    in1 = 16'h1111;
    step(1);
    chk("b2b done1", 16'(done_a), 16'h1);
    in1 = 16'h2222;
    step(1);
    chk("b2b done2", 16'(done_a), 16'h1);
    in1 = 16'h3333;
    step(1);
    chk("b2b done3", 16'(done_a), 16'h1);
    start_port = 1'b0;
    step(1);
    chk("b2b done off", 16'(done_a), 16'h0);
    advance_to(2, 5);
    chk("b2b d2 seg", 16'(seg_a), 16'h30);

    advance_to(1, 5);
    reset = 1'b0;
    start_port = 1'b1;
    in1 = 16'hFFFF;
    in2 = 4'hF;
    step(1);
    chk("midrst an", 16'(an_a), 16'hF);
    chk("midrst seg", 16'(seg_a), 16'h7F);
    chk("midrst dp", 16'(dp_a), 16'h1);
    chk("midrst done", 16'(done_a), 16'h0);
    start_port = 1'b0;
    reset = 1'b1;
    e = 0;
    advance_to(0, 4);
    chk("midrst no latch seg", 16'(seg_a), 16'h40);
    chk("midrst no latch dp", 16'(dp_a), 16'h1);

    for (int i = 0; i < 3000; i++) begin
      start_port = ($urandom % 4 == 0);
      in1 = 16'($urandom);
      if ($urandom % 3 == 0) in1 = in1 & 16'h00FF;
      in2 = 4'($urandom);
      reset = ($urandom % 300 != 0);
      step(1);
    end
    reset = 1'b1;
    start_port = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sseg_ctrl.md
Name: sseg_ctrl

Overview:
- Output-side counterpart to the button debouncer: drives a 4-digit multiplexed, common-anode seven-segment display from a value written by the HLS-generated accelerator.
- Accelerator writes 16-bit value plus decimal-point mask through a start/done handshake.
- Block latches the data, then continuously time-multiplexes the four digits with an anti-ghosting guard interval and optional leading-zero blanking.

Parameters:
- REFRESH_CLOCKS, 4096, clock cycles per digit slot; legal 2..65536.
- GUARD_CLOCKS, 16, cycles at the start of each slot with all anodes off; legal 0..REFRESH_CLOCKS-1.
- BLANK_ZEROS, 0, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start_port  input  1  write strobe; latches in1/in2 this cycle.
- in1  input  16  display value, nibble k shown on digit k (digit 0 = rightmost).
- in2  input  4  decimal-point mask, bit k lights dp on digit k.
- done_port  output  1  one-cycle acknowledge.
- an  output  4  anode enables, active-low, an[k] = digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (reset==0 at posedge): val=0, mask=0, cnt=0, idx=0, done_port=0, an=4'hF, seg=7'h7F, dp=1. Reset mid-scan or mid-handshake aborts; no done pulse follows.
- Write: start_port=1 at edge N -> val<=in1, mask<=in2 at N; done_port=1 for cycle after N only. Back-to-back starts accepted every cycle; done_port stays high, last write wins. No start -> val/mask hold.
- Scan counter: 16-bit cnt counts 0..REFRESH_CLOCKS-1. At REFRESH_CLOCKS-1: cnt<=0, idx<=idx+1 mod 4 (3 wraps to 0). Runs freely out of reset; independent of start_port.
- Outputs registered; computed from state (cnt, idx, val, mask) of the current cycle, visible one cycle later:
  - cnt < GUARD_CLOCKS: an=4'hF, seg=7'h7F, dp=1.
  - Else: an = ~(1<<idx); seg = decode(val nibble idx); dp = ~mask[idx].
  - A write changes the displayed pattern on the cycle after the latch, even mid-slot.
- Decode (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Leading-zero blanking (BLANK_ZEROS=1):
  - Digit idx>0 shows seg=7'h7F when nibble idx and all higher nibbles are 0.
  - an still asserts for that digit; dp still follows mask.
  - Digit 0 is always decoded.
- Full frame = 4*REFRESH_CLOCKS cycles; each digit lit REFRESH_CLOCKS-GUARD_CLOCKS cycles per frame.

Test Plan:
- Reset hold 5 cycles, release -> an=F, seg=7F, dp=1, done_port=0. With REFRESH_CLOCKS=8, GUARD_CLOCKS=2: first an=E appears 3 cycles after release; idx advances every 8 cycles and wraps 3->0 after 32.
- start_port one cycle with in1=16'h12AF, in2=4'b0100 -> done_port high exactly one cycle. Over one frame, after each slot's guard:
  - digit0: an=E, seg=0E;
  - digit1: an=D, seg=08;
  - digit2: an=B, seg=24, dp=0;
  - digit3: an=7, seg=79.
- BLANK_ZEROS=1, in1=16'h0050 -> digit3 and digit2 seg=7F with an asserted; digit1 seg=12; digit0 seg=40. in1=16'h0000 -> only digit0 lit, showing 40.
- Write mid-slot 16'h0003 -> 16'h0008 while digit0 active -> seg changes 30->00 exactly 1 cycle after the latching edge; cnt/idx undisturbed.
- Three consecutive start cycles with in1 = 1111, 2222, 3333 -> done_port high 3 cycles; display shows 3333.
- Reset asserted mid-slot with start_port=1 on the same edge -> no latch, done_port=0, outputs return to reset values next cycle.
